udt_rx_parser: RTL and testbench

- Sits between the UDP receive stream and the UDT core logic.
- Consumes the 64-bit UDP payload AXI-Stream, extracts the 16-byte UDT header, and classifies each packet as data or control.
- Filters packets by destination socket ID and drops runt packets.
- Emits one header record per accepted packet on a valid/ready sideband, plus the remaining payload bytes on a registered AXI-Stream.

---
 rtl/udt_rx_parser.sv | 188 ++++++++++++++++++
 tb/tb_udt_rx_parser.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/udt_rx_parser.sv
// UDT receive parser: splits the UDP payload stream into a 16-byte header record
// and the remaining payload beats, with socket filtering and runt rejection.
module udt_rx_parser #(
    parameter int CNT_W = 32
) (
    input  logic             core_clk,
    input  logic             core_rst_n,
    input  logic             udp_rx_tvalid,
    output logic             udp_rx_tready,
    input  logic [63:0]      udp_rx_tdata,
    input  logic [7:0]       udp_rx_tkeep,
    input  logic             udp_rx_tlast,
    input  logic [31:0]      local_sock_id,
    output logic             hdr_valid,
    input  logic             hdr_ready,
    output logic             hdr_is_ctrl,
    output logic [31:0]      hdr_w0,
    output logic [31:0]      hdr_w1,
    output logic [31:0]      hdr_tstamp,
    output logic [31:0]      hdr_dst_sock,
    output logic             hdr_has_pld,
    output logic             pld_tvalid,
    input  logic             pld_tready,
    output logic [63:0]      pld_tdata,
    output logic [7:0]       pld_tkeep,
    output logic             pld_tlast,
    output logic [CNT_W-1:0] rx_pkt_cnt,
    output logic [CNT_W-1:0] runt_cnt,
    output logic [CNT_W-1:0] sock_drop_cnt
);

    // state | meaning
    // H0    | waiting for beat 0 (header words 0/1)
    // H1    | waiting for beat 1 (header words 2/3), classify and filter
    // PLD   | forwarding payload beats to pld_*
    // DROP  | discarding the rest of a filtered packet
    typedef enum logic [1:0] {H0, H1, PLD, DROP} state_t;

    state_t           state_q, state_d;
    logic             active_q;
    logic [31:0]      w0_q, w0_d, w1_q, w1_d;
    logic             hdr_valid_q, hdr_valid_d, hdr_is_ctrl_q, hdr_is_ctrl_d;
    logic [31:0]      hdr_w0_q, hdr_w0_d, hdr_w1_q, hdr_w1_d;
    logic [31:0]      hdr_ts_q, hdr_ts_d, hdr_dst_q, hdr_dst_d;
    logic             hdr_has_pld_q, hdr_has_pld_d;
    logic             pld_tvalid_q, pld_tvalid_d, pld_tlast_q, pld_tlast_d;
    logic [63:0]      pld_tdata_q, pld_tdata_d;
    logic [7:0]       pld_tkeep_q, pld_tkeep_d;
    logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d, runt_cnt_q, runt_cnt_d, sock_cnt_q, sock_cnt_d;
    logic             tready_c, xfer;
    logic [31:0]      word_a, word_b;
    logic             is_handshake;

    // Lower half of the beat is the earlier big-endian word.
    assign word_a = {udp_rx_tdata[7:0],   udp_rx_tdata[15:8],  udp_rx_tdata[23:16], udp_rx_tdata[31:24]};
    assign word_b = {udp_rx_tdata[39:32], udp_rx_tdata[47:40], udp_rx_tdata[55:48], udp_rx_tdata[63:56]};
    assign is_handshake = w0_q[31] && (w0_q[30:16] == 15'd0);
    assign xfer = udp_rx_tvalid && udp_rx_tready;
    // Ready is held low until the first clock after reset release.
    assign udp_rx_tready = tready_c && active_q;

    always_comb begin
        state_d        = state_q;
        tready_c       = 1'b0;
        w0_d           = w0_q;
        w1_d           = w1_q;
        hdr_valid_d    = hdr_valid_q && !hdr_ready;
        hdr_is_ctrl_d  = hdr_is_ctrl_q;
        hdr_w0_d       = hdr_w0_q;
        hdr_w1_d       = hdr_w1_q;
        hdr_ts_d       = hdr_ts_q;
        hdr_dst_d      = hdr_dst_q;
        hdr_has_pld_d  = hdr_has_pld_q;
        pld_tvalid_d   = pld_tvalid_q && !pld_tready;
        pld_tdata_d    = pld_tdata_q;
        pld_tkeep_d    = pld_tkeep_q;
        pld_tlast_d    = pld_tlast_q;
        rx_cnt_d       = rx_cnt_q;
        runt_cnt_d     = runt_cnt_q;
        sock_cnt_d     = sock_cnt_q;
        case (state_q)
            H0: begin
                tready_c = 1'b1;
                if (xfer) begin
                    w0_d = word_a;
                    w1_d = word_b;
                    if (udp_rx_tlast) runt_cnt_d = runt_cnt_q + CNT_W'(1);
                    else              state_d    = H1;
                end
            end
            H1: begin
                tready_c = !hdr_valid_q;
                if (xfer) begin
                    if (udp_rx_tlast && udp_rx_tkeep != 8'hFF) begin
                        runt_cnt_d = runt_cnt_q + CNT_W'(1);
                        state_d    = H0;
                    end else if (word_b != local_sock_id && !is_handshake) begin
                        sock_cnt_d = sock_cnt_q + CNT_W'(1);
                        state_d    = udp_rx_tlast ? H0 : DROP;
                    end else begin
                        hdr_valid_d   = 1'b1;
                        hdr_is_ctrl_d = w0_q[31];
                        hdr_w0_d      = {1'b0, w0_q[30:0]};
                        hdr_w1_d      = w1_q;
                        hdr_ts_d      = word_a;
                        hdr_dst_d     = word_b;
                        hdr_has_pld_d = !udp_rx_tlast;
                        rx_cnt_d      = rx_cnt_q + CNT_W'(1);
                        state_d       = udp_rx_tlast ? H0 : PLD;
                    end
                end
            end
            PLD: begin
                tready_c = !pld_tvalid_q || pld_tready;
                if (xfer) begin
                    pld_tvalid_d = 1'b1;
                    pld_tdata_d  = udp_rx_tdata;
                    pld_tkeep_d  = udp_rx_tkeep;
                    pld_tlast_d  = udp_rx_tlast;
                    if (udp_rx_tlast) state_d = H0;
                end
            end
            DROP: begin
                tready_c = 1'b1;
                if (xfer && udp_rx_tlast) state_d = H0;
            end
            default: state_d = H0;
        endcase
    end

    always_ff @(posedge core_clk or negedge core_rst_n) begin
        if (!core_rst_n) begin
            state_q       <= H0;
            active_q      <= 1'b0;
            w0_q          <= '0;
            w1_q          <= '0;
            hdr_valid_q   <= 1'b0;
            hdr_is_ctrl_q <= 1'b0;
            hdr_w0_q      <= '0;
            hdr_w1_q      <= '0;
            hdr_ts_q      <= '0;
            hdr_dst_q     <= '0;
            hdr_has_pld_q <= 1'b0;
            pld_tvalid_q  <= 1'b0;
            pld_tdata_q   <= '0;
            pld_tkeep_q   <= '0;
            pld_tlast_q   <= 1'b0;
            rx_cnt_q      <= '0;
            runt_cnt_q    <= '0;
            sock_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            active_q      <= 1'b1;
            w0_q          <= w0_d;
            w1_q          <= w1_d;
            hdr_valid_q   <= hdr_valid_d;
            hdr_is_ctrl_q <= hdr_is_ctrl_d;
            hdr_w0_q      <= hdr_w0_d;
            hdr_w1_q      <= hdr_w1_d;
            hdr_ts_q      <= hdr_ts_d;
            hdr_dst_q     <= hdr_dst_d;
            hdr_has_pld_q <= hdr_has_pld_d;
            pld_tvalid_q  <= pld_tvalid_d;
            pld_tdata_q   <= pld_tdata_d;
            pld_tkeep_q   <= pld_tkeep_d;
            pld_tlast_q   <= pld_tlast_d;
            rx_cnt_q      <= rx_cnt_d;
            runt_cnt_q    <= runt_cnt_d;
            sock_cnt_q    <= sock_cnt_d;
        end
    end

    assign hdr_valid     = hdr_valid_q;
    assign hdr_is_ctrl   = hdr_is_ctrl_q;
    assign hdr_w0        = hdr_w0_q;
    assign hdr_w1        = hdr_w1_q;
    assign hdr_tstamp    = hdr_ts_q;
    assign hdr_dst_sock  = hdr_dst_q;
    assign hdr_has_pld   = hdr_has_pld_q;
    assign pld_tvalid    = pld_tvalid_q;
    assign pld_tdata     = pld_tdata_q;
    assign pld_tkeep     = pld_tkeep_q;
    assign pld_tlast     = pld_tlast_q;
    assign rx_pkt_cnt    = rx_cnt_q;
    assign runt_cnt      = runt_cnt_q;
    assign sock_drop_cnt = sock_cnt_q;

endmodule

// File: tb/tb_udt_rx_parser.sv
// Directed bench for udt_rx_parser: header records and payload beats are captured
// at the negedge before each handshake and compared with hand-built expectations.
module tb_udt_rx_parser;

    logic        core_clk = 1'b0;
    logic        core_rst_n;
    logic        udp_rx_tvalid, udp_rx_tready, udp_rx_tlast;
    logic [63:0] udp_rx_tdata;
    logic [7:0]  udp_rx_tkeep;
    logic [31:0] local_sock_id;
    logic        hdr_valid, hdr_ready, hdr_is_ctrl, hdr_has_pld;
    logic [31:0] hdr_w0, hdr_w1, hdr_tstamp, hdr_dst_sock;
    logic        pld_tvalid, pld_tready, pld_tlast;
    logic [63:0] pld_tdata;
    logic [7:0]  pld_tkeep;
    logic [31:0] rx_pkt_cnt, runt_cnt, sock_drop_cnt;
    logic        tog_en;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [129:0] hq[$];
    logic [72:0]  pq[$];

    udt_rx_parser #(.CNT_W(32)) dut (
        .core_clk(core_clk), .core_rst_n(core_rst_n),
        .udp_rx_tvalid(udp_rx_tvalid), .udp_rx_tready(udp_rx_tready),
        .udp_rx_tdata(udp_rx_tdata), .udp_rx_tkeep(udp_rx_tkeep), .udp_rx_tlast(udp_rx_tlast),
        .local_sock_id(local_sock_id),
        .hdr_valid(hdr_valid), .hdr_ready(hdr_ready), .hdr_is_ctrl(hdr_is_ctrl),
        .hdr_w0(hdr_w0), .hdr_w1(hdr_w1), .hdr_tstamp(hdr_tstamp), .hdr_dst_sock(hdr_dst_sock),
        .hdr_has_pld(hdr_has_pld),
        .pld_tvalid(pld_tvalid), .pld_tready(pld_tready), .pld_tdata(pld_tdata),
        .pld_tkeep(pld_tkeep), .pld_tlast(pld_tlast),
        .rx_pkt_cnt(rx_pkt_cnt), .runt_cnt(runt_cnt), .sock_drop_cnt(sock_drop_cnt)
    );

    always #5 core_clk = ~core_clk;

    // All stimulus changes at posedge+1, so negedge values hold through the next edge.
    initial begin
        pld_tready = 1'b1;
        forever begin
            @(posedge core_clk);
            #1;
            pld_tready = tog_en ? ~pld_tready : 1'b1;
        end
    end

    always @(negedge core_clk) begin
        if (hdr_valid && hdr_ready)
            hq.push_back({hdr_is_ctrl, hdr_w0, hdr_w1, hdr_tstamp, hdr_dst_sock, hdr_has_pld});
        if (pld_tvalid && pld_tready)
            pq.push_back({pld_tlast, pld_tkeep, pld_tdata});
    end

    task automatic check(input string tag, input logic [129:0] obs, input logic [129:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] bw(input logic [31:0] a, input logic [31:0] b);
        return {b[7:0], b[15:8], b[23:16], b[31:24], a[7:0], a[15:8], a[23:16], a[31:24]};
    endfunction

    function automatic logic [129:0] pop_h();
        if (hq.size() != 0) return hq.pop_front();
        return 'x;
    endfunction

    function automatic logic [72:0] pop_p();
        if (pq.size() != 0) return pq.pop_front();
        return 'x;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge core_clk);
        #1;
    endtask

    task automatic drive_beat(input logic [63:0] d, input logic [7:0] k, input logic l);
        udp_rx_tvalid = 1'b1;
        udp_rx_tdata  = d;
        udp_rx_tkeep  = k;
        udp_rx_tlast  = l;
    endtask

    task automatic wait_xfer();
        int  n = 0;
        bit  done = 1'b0;
        while (!done && n < 200) begin
            @(negedge core_clk);
            if (udp_rx_tready) done = 1'b1;
            @(posedge core_clk);
            #1;
            n++;
        end
        if (!done) check("xfer_timeout", udp_rx_tready, 1'b1);
        udp_rx_tvalid = 1'b0;
    endtask

    task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l);
        drive_beat(d, k, l);
        wait_xfer();
    endtask

    initial begin
        logic [63:0] d2, d3;
        logic [63:0] p [4];
        core_rst_n    = 1'b0;
        udp_rx_tvalid = 1'b0;
        udp_rx_tdata  = '0;
        udp_rx_tkeep  = '0;
        udp_rx_tlast  = 1'b0;
        local_sock_id = 32'h1234;
        hdr_ready     = 1'b1;
        tog_en        = 1'b0;
        #1;
        check("rst_tready", udp_rx_tready, 1'b0);
        check("rst_hdr_valid", hdr_valid, 1'b0);
        check("rst_pld_tvalid", pld_tvalid, 1'b0);
        check("rst_counters", {rx_pkt_cnt, runt_cnt, sock_drop_cnt}, 96'h0);
        idle(2);
        core_rst_n = 1'b1;
        idle(1);

        // Data packet with two payload beats
        d2 = 64'h0807060504030201;
        d3 = 64'h000000000C0B0A09;
        send_beat(bw(32'h0000_0005, 32'hAABB_CCDD), 8'hFF, 1'b0);
        send_beat(bw(32'h1122_3344, 32'h0000_1234), 8'hFF, 1'b0);
        check("t1_hdr_latency", hdr_valid, 1'b1);
        send_beat(d2, 8'hFF, 1'b0);
        check("t1_pld_latency", {pld_tvalid, pld_tdata}, {1'b1, d2});
        send_beat(d3, 8'h0F, 1'b1);
        idle(4);
        check("t1_hdr_count", hq.size(), 1);
        check("t1_hdr", pop_h(), {1'b0, 32'h5, 32'hAABBCCDD, 32'h11223344, 32'h1234, 1'b1});
        check("t1_pld_count", pq.size(), 2);
        check("t1_pld0", pop_p(), {1'b0, 8'hFF, d2});
        check("t1_pld1", pop_p(), {1'b1, 8'h0F, d3});
        check("t1_rx_cnt", rx_pkt_cnt, 32'd1);

        // Control ACK2, header only
        send_beat(bw(32'h8006_0000, 32'h0000_0007), 8'hFF, 1'b0);
        send_beat(bw(32'h0000_0099, 32'h0000_1234), 8'hFF, 1'b1);
        idle(4);
        check("t2_hdr", pop_h(), {1'b1, 32'h0006_0000, 32'h7, 32'h99, 32'h1234, 1'b0});
        check("t2_no_pld", pq.size(), 0);
        check("t2_rx_cnt", rx_pkt_cnt, 32'd2);

        // Runts: single beat, and short second beat
        send_beat(bw(32'h0000_0001, 32'h0), 8'hFF, 1'b1);
        send_beat(bw(32'h0000_0002, 32'h0), 8'hFF, 1'b0);
        send_beat(bw(32'h0000_0003, 32'h0), 8'h0F, 1'b1);
        idle(4);
        check("t3_runt_cnt", runt_cnt, 32'd2);
        check("t3_no_hdr", hq.size(), 0);
        check("t3_no_pld", pq.size(), 0);
        check("t3_rx_cnt", rx_pkt_cnt, 32'd2);

        // Socket mismatch dropped; handshake with dst 0 accepted
        send_beat(bw(32'h0000_0007, 32'h0), 8'hFF, 1'b0);
        send_beat(bw(32'h0, 32'h0000_9999), 8'hFF, 1'b0);
        send_beat(64'hDEAD_BEEF_0000_0001, 8'hFF, 1'b0);
        send_beat(64'hDEAD_BEEF_0000_0002, 8'h03, 1'b1);
        idle(4);
        check("t4_sock_cnt", sock_drop_cnt, 32'd1);
        check("t4_drop_no_out", {hq.size(), pq.size()}, 64'd0);
        send_beat(bw(32'h8000_0000, 32'h0000_0005), 8'hFF, 1'b0);
        send_beat(bw(32'h0000_0006, 32'h0), 8'hFF, 1'b1);
        idle(4);
        check("t4_handshake", pop_h(), {1'b1, 32'h0, 32'h5, 32'h6, 32'h0, 1'b0});
        check("t4_rx_cnt", rx_pkt_cnt, 32'd3);

        // Header backpressure then payload with toggling pld_tready
        hdr_ready = 1'b0;
        send_beat(bw(32'h8002_0000, 32'h0000_0001), 8'hFF, 1'b0);
        send_beat(bw(32'h0000_0002, 32'h0000_1234), 8'hFF, 1'b1);
        send_beat(bw(32'h0000_0009, 32'h0000_0003), 8'hFF, 1'b0);
        drive_beat(bw(32'h0000_0004, 32'h0000_1234), 8'hFF, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge core_clk);
            check("t5_tready_held", udp_rx_tready, 1'b0);
            check("t5_hdr_stable", {hdr_valid, hdr_w1}, {1'b1, 32'h1});
            @(posedge core_clk);
            #1;
        end
        hdr_ready = 1'b1;
        wait_xfer();
        tog_en = 1'b1;
        p[0] = 64'h1111_1111_1111_1111;
        p[1] = 64'h2222_2222_2222_2222;
        p[2] = 64'h3333_3333_3333_3333;
        p[3] = 64'h0000_4444_4444_4444;
        for (int i = 0; i < 4; i++)
            send_beat(p[i], (i == 3) ? 8'h3F : 8'hFF, i == 3);
        idle(8);
        tog_en = 1'b0;
        idle(2);
        check("t5_hdr_count", hq.size(), 2);
        check("t5_hdr_a", pop_h(), {1'b1, 32'h0002_0000, 32'h1, 32'h2, 32'h1234, 1'b0});
        check("t5_hdr_b", pop_h(), {1'b0, 32'h9, 32'h3, 32'h4, 32'h1234, 1'b1});
        check("t5_pld_count", pq.size(), 4);
        check("t5_pld0", pop_p(), {1'b0, 8'hFF, p[0]});
        check("t5_pld1", pop_p(), {1'b0, 8'hFF, p[1]});
        check("t5_pld2", pop_p(), {1'b0, 8'hFF, p[2]});
        check("t5_pld3", pop_p(), {1'b1, 8'h3F, p[3]});
        check("t5_rx_cnt", rx_pkt_cnt, 32'd5);

        // Reset in the middle of a payload
        send_beat(bw(32'h0000_0010, 32'h0), 8'hFF, 1'b0);
        send_beat(bw(32'h0, 32'h0000_1234), 8'hFF, 1'b0);
        send_beat(64'hCAFE_F00D_0000_0000, 8'hFF, 1'b0);
        check("t6_pld_before_rst", pld_tvalid, 1'b1);
        core_rst_n = 1'b0;
        #1;
        check("t6_rst_pld", {pld_tvalid, pld_tdata, pld_tkeep, pld_tlast}, 74'h0);
        check("t6_rst_hdr", {hdr_valid, hdr_w0, hdr_dst_sock}, 65'h0);
        check("t6_rst_tready", udp_rx_tready, 1'b0);
        check("t6_rst_counters", {rx_pkt_cnt, runt_cnt, sock_drop_cnt}, 96'h0);
        idle(2);
        core_rst_n = 1'b1;
        hq.delete();
        pq.delete();
        idle(1);
        send_beat(bw(32'h8005_0000, 32'h0), 8'hFF, 1'b0);
        send_beat(bw(32'h0000_0077, 32'h0000_1234), 8'hFF, 1'b1);
        idle(4);
        check("t6_after_rst_hdr", pop_h(), {1'b1, 32'h0005_0000, 32'h0, 32'h77, 32'h1234, 1'b0});
        check("t6_after_rst_cnts", {rx_pkt_cnt, runt_cnt, sock_drop_cnt}, {32'd1, 32'd0, 32'd0});
        check("t6_after_rst_no_pld", pq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
